// File: rtl/ultrasonido_ctrl.sv
// Ultrasonic ranger sequencer: periodic trigger, echo timing, cm conversion
// and a hysteretic "object near" flag. All timing is derived from clk.
`timescale 1ns/1ps
module ultrasonido_ctrl #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TRIG_US     = 10,
    parameter int PERIOD_MS   = 60,
    parameter int TIMEOUT_US  = 25000,
    parameter int NEAR_CM     = 20,
    parameter int HYST_CM     = 3,
    parameter int DIST_W      = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              echo,
    output logic              trig,
    output logic [DIST_W-1:0] dist_cm,
    output logic              dist_valid,
    output logic              timeout,
    output logic              near,
    output logic              busy
);

    localparam int CPU        = CLK_FREQ_HZ / 1_000_000;
    localparam int TRIG_CYC   = TRIG_US * CPU;
    // Split the product so the default 60 ms period does not overflow 32 bits.
    localparam int PERIOD_CYC = PERIOD_MS * (CLK_FREQ_HZ / 1000);
    localparam int TMO_CYC    = TIMEOUT_US * CPU;
    localparam int MAX_CYC    = (PERIOD_CYC > TMO_CYC) ? PERIOD_CYC : TMO_CYC;
    localparam int CNT_W      = $clog2(MAX_CYC + 1);
    localparam int PRE_W      = (CPU > 1) ? $clog2(CPU) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CPU - 1);
    localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TMO_CYC - 1);
    localparam logic [CNT_W-1:0]  PER_LAST  = CNT_W'(PERIOD_CYC - 1);
    localparam logic [5:0]        SUB_LAST  = 6'd57;   // 58 us of round trip per cm
    localparam logic [DIST_W-1:0] CM_MAX    = '1;
    localparam logic [DIST_W-1:0] NEAR_SET  = DIST_W'(NEAR_CM);
    localparam logic [DIST_W-1:0] NEAR_CLR  = DIST_W'(NEAR_CM + HYST_CM);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;        // per-state cycle counter
    logic [CNT_W-1:0]  period_q, period_d;  // cycles since trig rose
    logic [5:0]        sub_q, sub_d;
    logic [DIST_W-1:0] cm_q, cm_d;
    logic [DIST_W-1:0] dist_q, dist_d;
    logic              valid_q, valid_d;
    logic              tmo_q, tmo_d;
    logic              near_q, near_d;

    logic              echo_meta_q, echo_sync_q, echo_prev_q;
    logic              echo_rise, echo_fall, us_tick;
    logic [5:0]        sub_inc;
    logic [DIST_W-1:0] cm_inc;

    // Free-running microsecond prescaler.
    always_comb begin
        us_tick = (presc_q == PRE_LAST);
        presc_d = us_tick ? '0 : presc_q + PRE_W'(1);
    end

    // Echo synchronizer plus one extra stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta_q <= 1'b0;
            echo_sync_q <= 1'b0;
            echo_prev_q <= 1'b0;
        end else begin
            echo_meta_q <= echo;
            echo_sync_q <= echo_meta_q;
            echo_prev_q <= echo_sync_q;
        end
    end

    assign echo_rise = echo_sync_q & ~echo_prev_q;
    assign echo_fall = ~echo_sync_q & echo_prev_q;

    // Centimetre counting: the tick in the current cycle is included so the
    // value latched on the falling edge covers the whole echo width.
    always_comb begin
        sub_inc = sub_q;
        cm_inc  = cm_q;
        if (us_tick) begin
            if (sub_q == SUB_LAST) begin
                sub_inc = '0;
                cm_inc  = (cm_q == CM_MAX) ? cm_q : cm_q + DIST_W'(1);
            end else begin
                sub_inc = sub_q + 6'd1;
            end
        end
    end

    // Measurement sequencer: next state, counters and result registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        period_d = period_q + CNT_W'(1);
        sub_d    = sub_q;
        cm_d     = cm_q;
        dist_d   = dist_q;
        valid_d  = 1'b0;
        tmo_d    = 1'b0;
        near_d   = near_q;
        case (state_q)
            IDLE: begin
                cnt_d    = '0;
                period_d = '0;
                if (enable) state_d = TRIG;
            end
            TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                // Only a fresh edge starts a measurement; a level already high
                // on entry must fall and rise again.
                if (echo_rise) begin
                    cnt_d   = '0;
                    sub_d   = '0;
                    cm_d    = '0;
                    state_d = MEASURE;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    near_d  = 1'b0;
                    state_d = HOLDOFF;
                end
            end
            MEASURE: begin
                sub_d = sub_inc;
                cm_d  = cm_inc;
                if (echo_fall) begin
                    dist_d  = cm_inc;
                    valid_d = 1'b1;
                    if (cm_inc <= NEAR_SET) begin
                        near_d = 1'b1;
                    end else if (cm_inc > NEAR_CLR) begin
                        near_d = 1'b0;
                    end
                    state_d = HOLDOFF;
                end else if (cnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    near_d  = 1'b0;
                    state_d = HOLDOFF;
                end
            end
            HOLDOFF: begin
                // Leaving here restarts both counters so the next trig rise
                // lands exactly one period after the previous one.
                if (period_q >= PER_LAST) begin
                    cnt_d    = '0;
                    period_d = '0;
                    state_d  = enable ? TRIG : IDLE;
                end
            end
            default: begin
                cnt_d    = '0;
                period_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            sub_q    <= '0;
            cm_q     <= '0;
            dist_q   <= '0;
            valid_q  <= 1'b0;
            tmo_q    <= 1'b0;
            near_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            sub_q    <= sub_d;
            cm_q     <= cm_d;
            dist_q   <= dist_d;
            valid_q  <= valid_d;
            tmo_q    <= tmo_d;
            near_q   <= near_d;
        end
    end

    assign trig       = (state_q == TRIG);
    assign busy       = (state_q != IDLE);
    assign dist_cm    = dist_q;
    assign dist_valid = valid_q;
    assign timeout    = tmo_q;
    assign near       = near_q;

endmodule

// File: tb/tb_ultrasonido_ctrl.sv
// Bench for ultrasonido_ctrl, scaled to a 2 MHz clock and a 3 ms period so
// every scenario fits a short run; echo widths stay in real microseconds.
`timescale 1ns/1ps
module tb_ultrasonido_ctrl;

    localparam int CLK_FREQ_HZ = 2_000_000;
    localparam int CPU         = 2;
    localparam int TRIG_US     = 10;
    localparam int PERIOD_MS   = 3;
    localparam int TIMEOUT_US  = 2000;
    localparam int NEAR_CM     = 20;
    localparam int HYST_CM     = 3;
    localparam int DIST_W      = 5;
    localparam int TRIG_CYC    = TRIG_US * CPU;
    localparam int PERIOD_CYC  = PERIOD_MS * 1000 * CPU;
    localparam int TIMEOUT_CYC = TIMEOUT_US * CPU;
    localparam int DMAX        = (1 << DIST_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n, enable, echo;
    logic              trig, dist_valid, timeout, near, busy;
    logic [DIST_W-1:0] dist_cm;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_trig_rises = 0;
    int last_rise = 0;
    bit period_chk = 0;
    bit exp_near = 0;
    int exp_dist = 0;
    int hw[5];
    int rises;
    bit found;

    int v_cyc[$], v_dist[$], v_near[$];
    int t_cyc[$], t_dist[$], t_near[$];
    logic [DIST_W-1:0] exp_q[$];

    ultrasonido_ctrl #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ), .TRIG_US(TRIG_US), .PERIOD_MS(PERIOD_MS),
        .TIMEOUT_US(TIMEOUT_US), .NEAR_CM(NEAR_CM), .HYST_CM(HYST_CM), .DIST_W(DIST_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .echo(echo), .trig(trig),
        .dist_cm(dist_cm), .dist_valid(dist_valid), .timeout(timeout),
        .near(near), .busy(busy)
    );

    // Clock and cycle stamp
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference rule for the presence flag
    function automatic bit near_model(input bit prev, input int d);
        if (d <= NEAR_CM) return 1'b1;
        if (d > NEAR_CM + HYST_CM) return 1'b0;
        return prev;
    endfunction

    // Event monitor sampled on the falling edge
    initial begin
        logic trig_prev;
        trig_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (trig === 1'b1 && trig_prev !== 1'b1) n_trig_rises++;
            trig_prev = trig;
            if (dist_valid === 1'b1 || timeout === 1'b1)
                chk("strobe_exclusive", int'(dist_valid === 1'b1 && timeout === 1'b1), 0);
            if (dist_valid === 1'b1) begin
                v_cyc.push_back(cyc);
                v_dist.push_back(int'(dist_cm));
                v_near.push_back(int'(near));
            end
            if (timeout === 1'b1) begin
                t_cyc.push_back(cyc);
                t_dist.push_back(int'(dist_cm));
                t_near.push_back(int'(near));
            end
        end
    end

    // One full measurement period: width_us == 0 means no echo at all.
    task automatic run_meas(input int delay_us, input int width_us, input bit drop_en);
        int  t0, tf, tfall, n, exp_d;
        bit  ok, exp_valid;
        ok = 0;
        for (int i = 0; i < PERIOD_CYC + 200; i++) begin
            @(negedge clk);
            if (trig === 1'b1) begin
                ok = 1;
                break;
            end
        end
        chk("trig_rise_seen", int'(ok), 1);
        if (!ok) return;
        t0 = cyc;
        if (period_chk) chk("trig_period", t0 - last_rise, PERIOD_CYC);
        last_rise = t0;
        v_cyc.delete(); v_dist.delete(); v_near.delete();
        t_cyc.delete(); t_dist.delete(); t_near.delete();
        n = 0;
        for (int i = 0; i < 1000 && trig === 1'b1; i++) begin
            n++;
            @(negedge clk);
        end
        chk("trig_width", n, TRIG_CYC);
        tf = cyc;
        if (drop_en) enable = 1'b0;
        tfall = 0;
        if (width_us > 0) begin
            repeat (delay_us * CPU) @(negedge clk);
            echo = 1'b1;
            repeat (width_us * CPU) @(negedge clk);
            echo = 1'b0;
            tfall = cyc;
        end
        while (cyc < t0 + PERIOD_CYC - 20) @(negedge clk);

        exp_valid = (width_us > 0) && (width_us < TIMEOUT_US);
        if (exp_valid) begin
            exp_d = width_us / 58;
            if (exp_d > DMAX) exp_d = DMAX;
            exp_q.push_back(exp_d[DIST_W-1:0]);
            exp_near = near_model(exp_near, exp_d);
            exp_dist = exp_d;
        end else begin
            exp_near = 1'b0;
        end
        chk("valid_count", v_cyc.size(), int'(exp_valid));
        chk("timeout_count", t_cyc.size(), int'(!exp_valid));
        if (exp_valid && v_cyc.size() > 0) begin
            logic [DIST_W-1:0] e;
            e = exp_q.pop_front();
            chk("dist_on_valid", v_dist[0], int'(e));
            chk("near_on_valid", v_near[0], int'(exp_near));
            chk("valid_latency_2to4", int'(v_cyc[0] - tfall >= 2 && v_cyc[0] - tfall <= 4), 1);
        end
        if (!exp_valid && t_cyc.size() > 0) begin
            chk("near_on_timeout", t_near[0], 0);
            chk("dist_on_timeout", t_dist[0], exp_dist);
            if (width_us == 0)
                chk("timeout_latency", int'(t_cyc[0] - tf >= TIMEOUT_CYC - 2 &&
                                            t_cyc[0] - tf <= TIMEOUT_CYC + 2), 1);
        end
        chk("dist_hold", int'(dist_cm), exp_dist);
        chk("near_hold", int'(near), int'(exp_near));
        period_chk = !drop_en;
    endtask

    // Watchdog
    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    // Directed sequence
    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        echo   = 1'b0;
        hw     = '{1160, 1276, 1392, 1334, 1160};
        repeat (3) @(negedge clk);
        chk("reset_trig", int'(trig), 0);
        chk("reset_dist", int'(dist_cm), 0);
        chk("reset_valid", int'(dist_valid), 0);
        chk("reset_timeout", int'(timeout), 0);
        chk("reset_near", int'(near), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_no_trig", n_trig_rises, 0);

        // Basic measurement, then a missing echo
        enable = 1'b1;
        run_meas(200, 1160, 0);
        run_meas(0, 0, 0);

        // Hysteresis walk: 20, 22, 24, 23, 20 cm
        foreach (hw[i]) run_meas(200, hw[i], 0);

        // Saturation below the timeout, then an echo longer than the timeout
        run_meas(200, 1900, 0);
        run_meas(200, 2100, 0);

        // Drop enable while waiting for the echo
        run_meas(200, 1160, 1);
        rises = n_trig_rises;
        repeat (PERIOD_CYC + 100) @(negedge clk);
        chk("drop_busy", int'(busy), 0);
        chk("drop_no_trig", n_trig_rises - rises, 0);

        // Asynchronous reset in the middle of a measurement
        enable = 1'b1;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (trig === 1'b1) begin
                found = 1;
                break;
            end
        end
        chk("rst_trig_seen", int'(found), 1);
        for (int i = 0; i < 1000 && trig === 1'b1; i++) @(negedge clk);
        repeat (400) @(negedge clk);
        echo = 1'b1;
        repeat (300) @(negedge clk);
        chk("measure_busy", int'(busy), 1);
        chk("measure_near_before_rst", int'(near), 1);
        rst_n = 1'b0;
        #1;
        chk("async_trig", int'(trig), 0);
        chk("async_dist", int'(dist_cm), 0);
        chk("async_near", int'(near), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_valid", int'(dist_valid), 0);
        chk("async_timeout", int'(timeout), 0);
        enable = 1'b0;
        echo   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rises = n_trig_rises;
        repeat (PERIOD_CYC) @(negedge clk);
        chk("post_rst_no_trig", n_trig_rises - rises, 0);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_dist", int'(dist_cm), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
